// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// memory-wait FSM states and a small forwarding-priority helper.
package hazard_pkg;

    // ALU operand source selects
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Data-memory wait FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Memory-stage result is younger than writeback, so it wins when both match
    function automatic logic [1:0] fwd_select(input logic hit_m, input logic hit_w);
        if (hit_m)
            return FWD_MEM;
        else if (hit_w)
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Variable-latency data-memory wait tracker. Tracks an outstanding access,
// counts wait cycles, abandons the access after MEM_TIMEOUT wait cycles and
// raises a sticky timeout flag.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
)
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_mem_req,
    input  logic i_mem_ack,
    output logic o_mem_stall,
    output logic o_timeout_err
);

    localparam int unsigned         CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MEM_TIMEOUT);

    mem_state_e         r_state;
    mem_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;

    // State, wait counter and sticky error registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state, counter update and stall request.
    // WAIT transitions depend only on ack/timeout, so a request that drops
    // mid-wait releases the stall but the FSM still waits for ack or timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        o_mem_stall = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_mem_stall = i_mem_req & ~i_mem_ack;
                if (i_mem_req && !i_mem_ack) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                o_mem_stall = i_mem_req & ~i_mem_ack & (r_cnt < CNT_MAX);
                if (i_mem_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_timeout_err = r_err;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RISC-V pipeline with
// variable-latency data-memory support (freeze F..M, bubble W while waiting).
// Optional performance counters are built when PIPE_HAZ_PERF_EN is defined;
// otherwise StallCnt/FlushCnt are constant zero.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned PERF_W      = 16
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] RS1D,
    input  logic [REG_ADDR_W-1:0] RS2D,
    input  logic [REG_ADDR_W-1:0] RS1E,
    input  logic [REG_ADDR_W-1:0] RS2E,
    input  logic [REG_ADDR_W-1:0] RDE,
    input  logic                  ResultSrcE0,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] RDM,
    input  logic [REG_ADDR_W-1:0] RDW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemReqM,
    input  logic                  MemAckM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MemTimeoutErr,
    output logic [PERF_W-1:0]     StallCnt,
    output logic [PERF_W-1:0]     FlushCnt
);

    logic w_mem_stall;
    logic w_lw_stall;
    logic w_hit_m_a;
    logic w_hit_w_a;
    logic w_hit_m_b;
    logic w_hit_w_b;

    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait (
        .i_clk         (clk),
        .i_rst         (reset),
        .i_mem_req     (MemReqM),
        .i_mem_ack     (MemAckM),
        .o_mem_stall   (w_mem_stall),
        .o_timeout_err (MemTimeoutErr)
    );

    assign w_hit_m_a = RegWriteM && (RDM != '0) && (RDM == RS1E);
    assign w_hit_w_a = RegWriteW && (RDW != '0) && (RDW == RS1E);
    assign w_hit_m_b = RegWriteM && (RDM != '0) && (RDM == RS2E);
    assign w_hit_w_b = RegWriteW && (RDW != '0) && (RDW == RS2E);

    // ALU operand forwarding selects
    always_comb begin
        ForwardAE = fwd_select(w_hit_m_a, w_hit_w_a);
        ForwardBE = fwd_select(w_hit_m_b, w_hit_w_b);
    end

    assign w_lw_stall = ResultSrcE0 && (RDE != '0) &&
                        ((RDE == RS1D) || (RDE == RS2D)) && !PCSrcE;

    // Stall/flush priority: memory wait, then taken branch, then load-use.
    // During a memory wait D/E are frozen rather than flushed so a pending
    // branch or load-use is re-evaluated once the access completes.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (w_mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

`ifdef PIPE_HAZ_PERF_EN
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    // Saturating stall/flush event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallF && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if ((FlushD || FlushE || FlushW) && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. Stimulus pushes hand-computed
// expected outputs per cycle; a monitor pops and compares on the falling edge.
// Expected counter values follow PIPE_HAZ_PERF_EN the same way the RTL does.
module tb_pipe_hazard_ctrl;

    localparam int unsigned RW = 5;
    localparam int unsigned PW = 16;
    localparam int unsigned EW = 12 + 2 * PW;

    logic          clk;
    logic          reset;
    logic [RW-1:0] RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
    logic          ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemAckM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          MemTimeoutErr;
    logic [PW-1:0] StallCnt, FlushCnt;

    logic [EW-1:0] q_exp[$];
    string         q_name[$];
    int            checks = 0;
    int            errors = 0;
    logic          e_err  = 1'b0;
    logic [PW-1:0] acc_s  = '0;
    logic [PW-1:0] acc_f  = '0;

    pipe_hazard_ctrl #(
        .REG_ADDR_W  (RW),
        .MEM_TIMEOUT (15),
        .PERF_W      (PW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .RS1D          (RS1D),
        .RS2D          (RS2D),
        .RS1E          (RS1E),
        .RS2E          (RS2E),
        .RDE           (RDE),
        .ResultSrcE0   (ResultSrcE0),
        .PCSrcE        (PCSrcE),
        .RDM           (RDM),
        .RDW           (RDW),
        .RegWriteM     (RegWriteM),
        .RegWriteW     (RegWriteW),
        .MemReqM       (MemReqM),
        .MemAckM       (MemAckM),
        .StallF        (StallF),
        .StallD        (StallD),
        .StallE        (StallE),
        .StallM        (StallM),
        .FlushD        (FlushD),
        .FlushE        (FlushE),
        .FlushW        (FlushW),
        .ForwardAE     (ForwardAE),
        .ForwardBE     (ForwardBE),
        .MemTimeoutErr (MemTimeoutErr),
        .StallCnt      (StallCnt),
        .FlushCnt      (FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_in();
        RS1D = '0; RS2D = '0; RS1E = '0; RS2E = '0; RDE = '0; RDM = '0; RDW = '0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemReqM = 1'b0; MemAckM = 1'b0;
    endtask

    // st = {StallF,StallD,StallE,StallM}, fl = {FlushD,FlushE,FlushW}
    task automatic exp(input logic [3:0] st, input logic [2:0] fl,
                       input logic [1:0] fa, input logic [1:0] fb, input string nm);
        logic [PW-1:0] es;
        logic [PW-1:0] ef;
`ifdef PIPE_HAZ_PERF_EN
        if (reset) begin
            acc_s = '0;
            acc_f = '0;
        end
        es = acc_s;
        ef = acc_f;
        if (!reset) begin
            if (st[3] && acc_s != '1) acc_s = acc_s + PW'(1);
            if ((|fl) && acc_f != '1) acc_f = acc_f + PW'(1);
        end
`else
        es = '0;
        ef = '0;
`endif
        q_exp.push_back({st, fl, fa, fb, e_err, es, ef});
        q_name.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        string         n;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n = q_name.pop_front();
                a = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                     ForwardAE, ForwardBE, MemTimeoutErr, StallCnt, FlushCnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s actual=%h expected=%h", n, a, e);
                end
            end
        end
    end

    initial begin
        clr_in();
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "reset_state");
        reset = 1'b0;

        // Forwarding
        RegWriteM = 1'b1; RDM = 5'd5; RS1E = 5'd5; RegWriteW = 1'b1; RDW = 5'd5;
        exp(4'b0000, 3'b000, 2'b10, 2'b00, "fwd_mem_wins");
        RDM = 5'd0;
        exp(4'b0000, 3'b000, 2'b01, 2'b00, "fwd_rdm_zero");
        RDM = 5'd9; RS2E = 5'd9; RS1E = 5'd3;
        exp(4'b0000, 3'b000, 2'b00, 2'b10, "fwd_b_mem");
        RegWriteM = 1'b0; RS2E = 5'd5; RS1E = 5'd5;
        exp(4'b0000, 3'b000, 2'b01, 2'b01, "fwd_wb_both");
        RDW = 5'd0;
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "fwd_rdw_zero");
        clr_in();

        // Load-use
        ResultSrcE0 = 1'b1; RDE = 5'd7; RS2D = 5'd7;
        exp(4'b1100, 3'b010, 2'b00, 2'b00, "lw_stall");
        PCSrcE = 1'b1;
        exp(4'b0000, 3'b110, 2'b00, 2'b00, "branch_over_lw");
        PCSrcE = 1'b0; RDE = 5'd0; RS2D = 5'd0;
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "lw_rde_zero");
        clr_in();
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "idle");

        // Memory wait with ack on third cycle
        MemReqM = 1'b1;
        exp(4'b1111, 3'b001, 2'b00, 2'b00, "mem_wait_c1");
        exp(4'b1111, 3'b001, 2'b00, 2'b00, "mem_wait_c2");
        MemAckM = 1'b1;
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "mem_ack_c3");
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "mem_single_cycle");
        clr_in();
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "mem_done");

        // Timeout: 15 stall cycles, no stall on 16th, sticky error after
        MemReqM = 1'b1;
        for (int i = 0; i < 15; i++)
            exp(4'b1111, 3'b001, 2'b00, 2'b00, "timeout_stall");
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "timeout_release");
        e_err = 1'b1;
        clr_in();
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "timeout_err_set");
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "timeout_err_sticky");

        // Memory stall overrides branch and load-use
        MemReqM = 1'b1; PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RDE = 5'd7; RS2D = 5'd7;
        exp(4'b1111, 3'b001, 2'b00, 2'b00, "mem_over_branch");
        MemAckM = 1'b1;
        exp(4'b0000, 3'b110, 2'b00, 2'b00, "branch_after_ack");
        clr_in();
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "post_branch");

        // Reset mid-WAIT (cnt reaches 4), then a fresh full-length timeout
        MemReqM = 1'b1;
        for (int i = 0; i < 4; i++)
            exp(4'b1111, 3'b001, 2'b00, 2'b00, "pre_reset_stall");
        MemReqM = 1'b0; reset = 1'b1; e_err = 1'b0;
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "reset_mid_wait");
        reset = 1'b0; MemReqM = 1'b1;
        for (int i = 0; i < 15; i++)
            exp(4'b1111, 3'b001, 2'b00, 2'b00, "post_reset_stall");
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "post_reset_release");
        e_err = 1'b1;
        clr_in();
        exp(4'b0000, 3'b000, 2'b00, 2'b00, "post_reset_err");

        for (int i = 0; i < 10 && q_exp.size() > 0; i++)
            @(negedge clk);
        #1;
        if (q_exp.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", q_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
